regfile_reader: RTL and testbench
=================================

// Module: regfile_reader
// PURPOSE
//  Read-side sequencer for the 16-entry register file: on start, sweeps addresses
//  0..DEPTH-1 through the register file read port and streams each word out on a
//  valid/ready interface. Also accumulates a running 32-bit checksum of the words sent.
//  Sits beside the write-side fill sequencer, on the register file's rdAddrA/rdDataA port.
// PARAMETERS
//  DATA_W  32  width of register file words, out_data and checksum
//  ADDR_W  4   register file address width
//  DEPTH   16  number of entries swept, 1..2**ADDR_W
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       synchronous, active-high reset
//  start      in   1       level-sampled sweep request
//  rdAddr     out  ADDR_W  register file read address (to rdAddrA)
//  rdData     in   DATA_W  register file read data (from rdDataA), combinational from rdAddr
//  out_data   out  DATA_W  word being presented
//  out_valid  out  1       out_data is valid
//  out_ready  in   1       downstream accepts the word
//  busy       out  1       sweep in progress (READ or SEND)
//  done       out  1       sweep complete; checksum is final
//  checksum   out  DATA_W  sum of accepted words, mod 2**DATA_W
// BEHAVIOUR
//  Reset: state=IDLE; rdAddr=0, out_data=0, out_valid=0, busy=0, done=0, checksum=0.
//   rst has priority over every other input in every state; a mid-sweep rst aborts
//   the sweep and drops out_valid on the next edge.
//  FSM states: IDLE, READ, SEND, DONE. Transitions are evaluated at the rising edge.
//   IDLE: if start=1 -> READ with addr=0 and checksum=0.
//   READ: rdAddr=addr; out_data<=rdData -> SEND.
//   SEND: out_valid=1 and out_data held stable.
//    If out_ready=1 (transfer): checksum<=checksum+out_data, wrapping mod 2**DATA_W.
//     Then if addr==DEPTH-1 -> DONE; otherwise addr<=addr+1 -> READ.
//    If out_ready=0: stay in SEND with all outputs unchanged.
//   DONE: done=1 and checksum held.
//    start=1 -> READ with addr=0 and checksum=0 (restart).
//    Otherwise stay in DONE until start or rst.
//  start is ignored in READ and SEND. A held start in DONE restarts immediately.
//  out_valid=1 only in SEND. busy=1 in READ and SEND. done=1 only in DONE.
//  rdAddr is registered: equals addr in READ and SEND, holds its last value in DONE,
//   and is 0 in IDLE.
//  Latency: start sampled at edge N -> READ during cycle N+1 -> out_valid=1 from edge N+2.
//  Throughput: at most one word per 2 cycles (READ+SEND). A full sweep with out_ready
//   tied high takes 2*DEPTH cycles from the first READ to DONE.
//  A transfer is the cycle where out_valid=1 and out_ready=1. Exactly DEPTH transfers
//   happen per sweep, in ascending address order; no duplicates, no skips.
//  out_ready is ignored outside SEND.
//  Register file contents changing mid-sweep: the word captured in READ is the one sent.
// TESTING
//  1 Preload regfile[i]=i+1, out_ready=1, start pulse -> 16 transfers with data 1..16
//    in order, then done=1 and checksum=136; out_valid first rises 2 cycles after start.
//  2 Backpressure: out_ready low for 5 cycles during word 3 -> out_valid and out_data
//    (=4) held stable for 5 cycles; no skip, no duplicate; final checksum=136.
//  3 Wrap: all entries 32'hFFFF_FFFF -> checksum=32'hFFFF_FFF0 at done.
//  4 rst asserted in SEND at word 7 -> next edge: out_valid=0, busy=0, checksum=0,
//    state IDLE; a new start then sweeps from address 0.
//  5 start held high through the sweep -> ignored while busy; on DONE, a restart occurs
//    with checksum cleared to 0 before the first new transfer.
//  6 All-zero register file -> 16 transfers of 0, checksum=0, done=1.

Source files
------------

// File: rtl/regfile_reader.sv
// Read-side sweep sequencer: walks the register file from address 0 to DEPTH-1,
// streams each word on a valid/ready port and keeps a running checksum.
//
// state | meaning
// IDLE  | waiting for start, rdAddr parked at 0
// READ  | rdAddr driven, capture rdData into out_data
// SEND  | out_data presented, waiting for out_ready
// DONE  | sweep complete, checksum final
module regfile_reader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rdAddr,
    input  logic [DATA_W-1:0] rdData,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t state, state_nxt;
    logic   xfer;
    logic   last_word;

    assign xfer      = (state == SEND) && out_ready;
    assign last_word = (rdAddr == LAST_ADDR);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = READ;
            READ: begin
                busy      = 1'b1;
                state_nxt = SEND;
            end
            SEND: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = last_word ? DONE : READ;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nxt = READ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // rdAddr doubles as the sweep address; it is left on the last entry in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            rdAddr   <= '0;
            out_data <= '0;
            checksum <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        rdAddr   <= '0;
                        checksum <= '0;
                    end
                end
                READ: out_data <= rdData;
                SEND: begin
                    if (xfer) begin
                        checksum <= checksum + out_data;
                        if (!last_word) rdAddr <= rdAddr + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_reader.sv
// Bench for regfile_reader: a scoreboard queue of expected words is filled by the
// stimulus and drained by a monitor on every transfer.
module tb_regfile_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  rdAddr;
    logic [31:0] rdData;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic [31:0] checksum;

    logic [31:0] mem [16];
    logic [31:0] exp_q [$];

    int errors = 0;
    int checks = 0;
    int xfers  = 0;

    assign rdData = mem[rdAddr];

    always #5 clk = ~clk;

    regfile_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rdAddr    (rdAddr),
        .rdData    (rdData),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: pops one expected word per transfer, and checks that a stalled word stays put
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", {31'd0, out_valid}, 32'd1);
                check("stall_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                xfers++;
                if (exp_q.size() == 0) begin
                    check("unexpected_xfer", out_data, 32'hDEAD_BEEF);
                end else begin
                    check("xfer_data", out_data, exp_q.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(mem[i % 16]);
    endtask

    // counts edges until done; expired budget is reported as a failed check
    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (!done && cycles < budget) begin
            tick();
            cycles++;
        end
        if (!done) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    int cyc;

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = 32'(i + 1);
        tick();
        tick();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_checksum", checksum, 32'd0);
        check("rst_addr", {28'd0, rdAddr}, 32'd0);
        check("rst_data", out_data, 32'd0);
        rst = 1'b0;
        tick();

        // 1: basic sweep, latency and sweep length
        push_words(16);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("lat_read_valid", {31'd0, out_valid}, 32'd0);
        check("lat_read_busy", {31'd0, busy}, 32'd1);
        tick();
        check("lat_send_valid", {31'd0, out_valid}, 32'd1);
        check("lat_first_data", out_data, 32'd1);
        wait_done(200, cyc);
        check("sweep_cycles", 32'(cyc + 2), 32'd33);
        check("t1_checksum", checksum, 32'd136);
        check("t1_left", 32'(exp_q.size()), 32'd0);
        check("t1_xfers", 32'(xfers), 32'd16);
        check("t1_addr_hold", {28'd0, rdAddr}, 32'd15);
        tick();
        check("t1_done_hold", {31'd0, done}, 32'd1);

        // 2: backpressure on word 3
        push_words(16);
        start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            start = 1'b0;
            if (c == 7) out_ready = 1'b0;
            if (c >= 8) begin
                check("bp_valid", {31'd0, out_valid}, 32'd1);
                check("bp_data", out_data, 32'd4);
            end
            if (c == 12) out_ready = 1'b1;
        end
        wait_done(200, cyc);
        check("t2_checksum", checksum, 32'd136);
        check("t2_left", 32'(exp_q.size()), 32'd0);

        // 3: checksum wraps
        for (int i = 0; i < 16; i++) mem[i] = 32'hFFFF_FFFF;
        push_words(16);
        pulse_start();
        wait_done(200, cyc);
        check("t3_checksum", checksum, 32'hFFFF_FFF0);
        check("t3_left", 32'(exp_q.size()), 32'd0);

        // 4: reset while presenting word 7
        for (int i = 0; i < 16; i++) mem[i] = 32'(i + 1);
        push_words(16);
        xfers = 0;
        start = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            start = 1'b0;
        end
        check("t4_pre_valid", {31'd0, out_valid}, 32'd1);
        check("t4_pre_data", out_data, 32'd8);
        rst = 1'b1;
        tick();
        check("t4_valid", {31'd0, out_valid}, 32'd0);
        check("t4_busy", {31'd0, busy}, 32'd0);
        check("t4_done", {31'd0, done}, 32'd0);
        check("t4_checksum", checksum, 32'd0);
        check("t4_addr", {28'd0, rdAddr}, 32'd0);
        check("t4_xfers", 32'(xfers), 32'd7);
        exp_q.delete();
        rst = 1'b0;
        tick();
        push_words(16);
        pulse_start();
        tick();
        check("t4_restart_data", out_data, 32'd1);
        wait_done(200, cyc);
        check("t4_checksum_end", checksum, 32'd136);
        check("t4_left", 32'(exp_q.size()), 32'd0);

        // 5: start held through the sweep restarts straight out of DONE
        push_words(32);
        start = 1'b1;
        tick();
        wait_done(200, cyc);
        check("t5_cycles", 32'(cyc + 1), 32'd33);
        check("t5_checksum", checksum, 32'd136);
        check("t5_left_mid", 32'(exp_q.size()), 32'd16);
        tick();
        start = 1'b0;
        check("t5_restart_busy", {31'd0, busy}, 32'd1);
        check("t5_restart_done", {31'd0, done}, 32'd0);
        check("t5_restart_cks", checksum, 32'd0);
        check("t5_restart_addr", {28'd0, rdAddr}, 32'd0);
        wait_done(200, cyc);
        check("t5_checksum_end", checksum, 32'd136);
        check("t5_left", 32'(exp_q.size()), 32'd0);

        // 6: all-zero contents
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        push_words(16);
        xfers = 0;
        pulse_start();
        wait_done(200, cyc);
        check("t6_checksum", checksum, 32'd0);
        check("t6_done", {31'd0, done}, 32'd1);
        check("t6_xfers", 32'(xfers), 32'd16);
        check("t6_left", 32'(exp_q.size()), 32'd0);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
